data_sram_responder: RTL
========================

Name: data_sram_responder

Overview:
Data-side SRAM responder for the pipelined CPU core. It services the data-RAM request issued from the execute stage (en / byte-write-enable / addr / wdata) and returns read data a fixed number of cycles later, in time for the memory stage. It has word-addressed storage, byte-lane write merging and an out-of-range error flag. It is used as the core's data memory in simulation and FPGA builds.

Parameters:
ADDR_WIDTH, 12, number of word-index bits; depth = 2^ADDR_WIDTH 32-bit words; legal range 2..16.
LATENCY, 1, cycles from request edge to response (rvalid/rdata); legal range 1..4.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
resetn  input  1  asynchronous, active-low reset.
data_sram_en  input  1  request valid; sampled every rising edge; no back-pressure.
data_sram_we  input  4  byte write enables; lane i covers wdata[8i+7:8i]; 4'b0000 means read.
data_sram_addr  input  32  byte address.
data_sram_wdata  input  32  write data.
data_sram_rdata  output  32  response data.
data_sram_rvalid  output  1  one-cycle pulse per accepted request, LATENCY cycles after it.
data_sram_err  output  1  asserted with rvalid when that request was out of range.

Behaviour:
- Reset (resetn low, asynchronous): rdata = 0, rvalid = 0, err = 0, all response pipeline stages cleared. Requests in flight are discarded and never responded to. Array contents are not reset; they are retained or undefined.
- Request accepted on any rising edge with en = 1 and resetn = 1. One request per cycle; back-to-back requests every cycle are supported. No stall path exists.
- Word index = addr[ADDR_WIDTH+1:2]. addr[1:0] is ignored: no alignment check, because the core aligns and shifts.
- In range: addr[31:ADDR_WIDTH+2] == 0. Out of range: any of those bits set.
- In-range write: at the request edge, each lane with we[i] = 1 is replaced by the wdata lane. Other lanes keep their old value.
- Read-first semantics: the response for any request (read or write) carries the word contents before that edge's write.
- Out-of-range request: no array write. Response data = 32'h0. err = 1 in the response cycle.
- Stage 0 captures {valid = en, data, err} at the request edge. Stages 1..LATENCY-1 form a plain shift register. Outputs are driven from stage LATENCY-1.
  - LATENCY = 1: response visible in the cycle after the request.
- Write followed by read of the same word on the next cycle returns the merged new value: the array is updated at the earlier edge.
- rdata holds the last response value while rvalid = 0. err is 0 whenever rvalid = 0.
- en = 0 with we != 0: ignored; no write, no response.
- resetn deassertion is assumed synchronised externally; the first request is accepted on the first edge with resetn high.

Optional Feature:
DSRAM_STAT_EN. When defined, two extra outputs are added:
- stat_rd_cnt (32-bit): counts accepted reads (en = 1, we = 0).
- stat_wr_cnt (32-bit): counts accepted writes (en = 1, we != 0).
- Both count out-of-range requests too. Both saturate at 32'hFFFF_FFFF and clear on reset.
When not defined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset check: hold resetn = 0 for 3 cycles, then release with en = 0 -> rdata = 0, rvalid = 0, err = 0 throughout; no rvalid pulse afterwards.
- Full write then read, LATENCY = 1: write addr 0x10, we = 4'hF, wdata 0xDEADBEEF; next cycle read 0x10 -> rvalid pulse one cycle after the read with rdata 0xDEADBEEF.
- Byte merge: word 0x20 holds 0x11223344; write we = 4'b0101, wdata 0xAABBCCDD; then read -> 0x11BB33DD. The write's own response returns 0x11223344.
- Out of range, ADDR_WIDTH = 12: write 0x0000_4000 then read 0x0000_4000 -> both responses have err = 1 and rdata = 0. Word 0 is unchanged.
- Pipelining, LATENCY = 3: reads of 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive rvalid pulses starting 3 cycles after the first request, data in order. Drop resetn mid-stream -> the remaining pulses are suppressed.
- DSRAM_STAT_EN defined: 5 reads, 3 writes, 1 out-of-range write, 2 idle cycles with we != 0 and en = 0 -> stat_rd_cnt = 5, stat_wr_cnt = 4; both read 0 after reset.

Source files
------------

// File: rtl/data_sram_responder_if.sv
// -----------------------------------------------------------------------------
// data_sram_responder_if
//   Data-RAM request/response bundle between the CPU core (master) and the
//   data SRAM responder (slave).
//
//   data_sram_en     request valid, sampled every rising edge, no back-pressure
//   data_sram_we     byte write enables, lane i covers wdata[8i+7:8i], 0 = read
//   data_sram_addr   byte address
//   data_sram_wdata  write data
//   data_sram_rdata  response data
//   data_sram_rvalid one-cycle pulse per accepted request
//   data_sram_err    out-of-range flag, valid with rvalid
// -----------------------------------------------------------------------------
interface data_sram_responder_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        data_sram_rvalid;
  logic        data_sram_err;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, data_sram_rvalid, data_sram_err
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, data_sram_rvalid, data_sram_err
  );
endinterface

// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//   Data-side SRAM for the pipelined core. Word-addressed storage of
//   2^ADDR_WIDTH 32-bit words with byte-lane write merging, read-first
//   response data and an out-of-range error flag. Every accepted request
//   (read or write) produces one rvalid pulse LATENCY cycles after its edge.
//
// Parameters
//   ADDR_WIDTH  word-index bits (2..16)
//   LATENCY     request edge to response, in cycles (1..4)
//
// Ports
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset (clears response pipeline only)
//   bus          data_sram_responder_if.slave request/response bundle
//   stat_rd_cnt  saturating count of accepted reads   (DSRAM_STAT_EN only)
//   stat_wr_cnt  saturating count of accepted writes  (DSRAM_STAT_EN only)
//
// Build option
//   DSRAM_STAT_EN  when defined, adds the two statistics counters and ports.
// -----------------------------------------------------------------------------
module data_sram_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  data_sram_responder_if.slave  bus
`ifdef DSRAM_STAT_EN
  ,
  output logic [31:0]           stat_rd_cnt,
  output logic [31:0]           stat_wr_cnt
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } stage_t;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  stage_t                stage_in;
  stage_t                pipe [LATENCY];

  // addr[1:0] is deliberately ignored: the core aligns and shifts itself.
  assign word_idx = bus.data_sram_addr[ADDR_WIDTH+1:2];
  assign in_range = (bus.data_sram_addr >> (ADDR_WIDTH + 2)) == 32'd0;

  // Stage 0 input. Data is only refreshed by an accepted request so that the
  // shift register carries the previous response forward; this is what makes
  // rdata hold its last value while rvalid is low. The array read happens
  // before this edge's write lands, giving read-first semantics.
  always_comb begin
    // NOTE: start from a full default so every path assigns every field and
    // no latch is inferred.
    stage_in       = pipe[0];
    stage_in.valid = bus.data_sram_en;
    stage_in.err   = bus.data_sram_en & ~in_range;
    if (bus.data_sram_en) begin
      stage_in.data = in_range ? mem[word_idx] : 32'h0;
    end
  end

  // NOTE: the storage array has no reset; clearing it would forbid RAM
  // inference and contents are allowed to survive reset.
  always_ff @(posedge clk) begin
    if (resetn && bus.data_sram_en && in_range) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (bus.data_sram_we[lane]) begin
          mem[word_idx][8*lane +: 8] <= bus.data_sram_wdata[8*lane +: 8];
        end
      end
    end
  end

  // Response pipeline: stage 0 captures, stages 1..LATENCY-1 shift.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < LATENCY; s++) begin
        pipe[s] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let every stage sample its
      // predecessor's old value, forming a true shift register.
      pipe[0] <= stage_in;
      for (int s = 1; s < LATENCY; s++) begin
        pipe[s] <= pipe[s-1];
      end
    end
  end

  assign bus.data_sram_rvalid = pipe[LATENCY-1].valid;
  assign bus.data_sram_err    = pipe[LATENCY-1].err;
  assign bus.data_sram_rdata  = pipe[LATENCY-1].data;

`ifdef DSRAM_STAT_EN
  // Out-of-range requests are counted too; both counters stick at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_rd_cnt <= 32'h0;
      stat_wr_cnt <= 32'h0;
    end else if (bus.data_sram_en) begin
      if (bus.data_sram_we == 4'h0) begin
        if (stat_rd_cnt != 32'hFFFF_FFFF) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      end else begin
        if (stat_wr_cnt != 32'hFFFF_FFFF) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
